pe_array_sys: RTL and testbench



---
 rtl/pe_array_sys.sv | 60 ++++++
 tb/tb_pe_array_sys.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pe_array_sys.sv
// pe_array_sys: weight-stationary systolic grid of signed multiply-accumulate PEs
module pe_array_sys #(
    parameter int ARRAY_SIZE             = 2,
    parameter int COMPUTE_DATA_WIDTH     = 4,
    parameter int ACCUMULATOR_DATA_WIDTH = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     compute,
    input  logic signed [COMPUTE_DATA_WIDTH-1:0]     ins        [ARRAY_SIZE],
    input  logic signed [COMPUTE_DATA_WIDTH-1:0]     weights_in [ARRAY_SIZE],
    output logic signed [ACCUMULATOR_DATA_WIDTH-1:0] results    [ARRAY_SIZE]
);
    localparam int N  = ARRAY_SIZE;
    localparam int CW = COMPUTE_DATA_WIDTH;
    localparam int AW = ACCUMULATOR_DATA_WIDTH;

    logic signed [CW-1:0]   w_q  [N][N];
    logic signed [CW-1:0]   w_d  [N][N];
    logic signed [CW-1:0]   a_q  [N][N];
    logic signed [CW-1:0]   a_d  [N][N];
    logic signed [2*CW-1:0] prod [N][N];
    logic signed [AW-1:0]   p_in [N][N];
    logic signed [AW-1:0]   p_q  [N][N];
    logic signed [AW-1:0]   p_d  [N][N];

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            if (c == 0) begin : g_a_edge
                assign a_d[r][c] = ins[r];
            end else begin : g_a_chain
                assign a_d[r][c] = a_q[r][c-1];
            end
            if (r == 0) begin : g_top
                assign w_d[r][c]  = weights_in[c];
                assign p_in[r][c] = '0;
            end else begin : g_below
                assign w_d[r][c]  = w_q[r-1][c];
                assign p_in[r][c] = p_q[r-1][c];
            end
            assign prod[r][c] = a_d[r][c] * w_q[r][c];
            assign p_d[r][c]  = p_in[r][c] + AW'(prod[r][c]);
        end
        assign results[r] = p_q[N-1][r];
    end

    // Load mode shifts weights down the columns; compute mode advances activations and partial sums.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_q <= '{default: '0};
            a_q <= '{default: '0};
            p_q <= '{default: '0};
        end else if (compute) begin
            a_q <= a_d;
            p_q <= p_d;
        end else begin
            w_q <= w_d;
        end
    end
endmodule

// File: tb/tb_pe_array_sys.sv
// tb_pe_array_sys: directed checks of load, skewed compute, signed range, hold and reset
module tb_pe_array_sys;
    logic               clk = 1'b0;
    logic               rst;
    logic               compute;
    logic signed [3:0]  ins        [2];
    logic signed [3:0]  weights_in [2];
    logic signed [15:0] results    [2];
    int                 passed = 0;
    int                 total  = 0;

    pe_array_sys #(
        .ARRAY_SIZE(2),
        .COMPUTE_DATA_WIDTH(4),
        .ACCUMULATOR_DATA_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .compute(compute),
        .ins(ins),
        .weights_in(weights_in),
        .results(results)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [15:0] obs, input logic signed [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int i0, input int i1);
        ins[0] = 4'(i0);
        ins[1] = 4'(i1);
    endtask

    task automatic load(input int w0, input int w1);
        compute = 1'b0;
        weights_in[0] = 4'(w0);
        weights_in[1] = 4'(w1);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        compute = 1'b1;
        set_in(5, 6);
        weights_in[0] = 4'sd7;
        weights_in[1] = -4'sd1;
        #2 rst = 1'b0;
        #1;
        chk("reset_async_r0", results[0], 0);
        chk("reset_async_r1", results[1], 0);
        tick();
        tick();
        chk("reset_held_r0", results[0], 0);
        chk("reset_held_r1", results[1], 0);
        rst = 1'b1;
        // weights: row0={1,2}, row1={3,4}
        load(3, 4);
        load(1, 2);
        chk("load_hold_r0", results[0], 0);
        chk("load_hold_r1", results[1], 0);
        compute = 1'b1;
        set_in(1, 0);
        tick();
        chk("basic_A_r0", results[0], 0);
        set_in(0, 2);
        tick();
        chk("basic_A1_r0", results[0], 7);
        chk("basic_A1_r1", results[1], 0);
        set_in(0, 0);
        tick();
        chk("basic_A2_r0", results[0], 0);
        chk("basic_A2_r1", results[1], 10);
        tick();
        chk("basic_A3_r1", results[1], 0);
        // signed extremes
        load(-8, -8);
        load(-8, -8);
        compute = 1'b1;
        set_in(-8, 0);
        tick();
        set_in(0, -8);
        tick();
        chk("ext_B1_r0", results[0], 128);
        chk("ext_B1_r1", results[1], 0);
        set_in(0, 0);
        tick();
        chk("ext_B2_r0", results[0], 0);
        chk("ext_B2_r1", results[1], 128);
        // freeze with live pipeline state, then reload weights
        set_in(1, 0);
        tick();
        set_in(0, 1);
        tick();
        chk("pre_hold_r0", results[0], -16);
        load(1, 1);
        chk("hold1_r0", results[0], -16);
        chk("hold1_r1", results[1], 0);
        load(2, 2);
        load(3, 3);
        load(5, 6);
        load(7, -2);
        chk("hold5_r0", results[0], -16);
        chk("hold5_r1", results[1], 0);
        // weights now row0={7,-2}, row1={5,6}; frozen p(0,1)=-8, a(1,0)=1 resume
        compute = 1'b1;
        set_in(0, 0);
        tick();
        chk("resume_r0", results[0], 0);
        chk("resume_r1", results[1], -2);
        tick();
        chk("flush_r1", results[1], 0);
        set_in(1, 0);
        tick();
        set_in(0, 1);
        tick();
        chk("neww_C1_r0", results[0], 12);
        set_in(0, 0);
        tick();
        chk("neww_C2_r0", results[0], 0);
        chk("neww_C2_r1", results[1], 4);
        // mid-compute reset
        set_in(1, 0);
        tick();
        set_in(0, 1);
        tick();
        chk("pre_rst_r0", results[0], 12);
        #2 rst = 1'b0;
        #1;
        chk("midrst_r0", results[0], 0);
        chk("midrst_r1", results[1], 0);
        #3 rst = 1'b1;
        compute = 1'b1;
        set_in(3, -5);
        tick();
        set_in(2, 4);
        tick();
        chk("cleared_w_r0", results[0], 0);
        set_in(1, 1);
        tick();
        chk("cleared_w_r0b", results[0], 0);
        chk("cleared_w_r1", results[1], 0);
        set_in(0, 0);
        tick();
        tick();
        load(1, 1);
        load(1, 1);
        compute = 1'b1;
        set_in(2, 0);
        tick();
        set_in(0, 3);
        tick();
        chk("reload_E1_r0", results[0], 5);
        set_in(0, 0);
        tick();
        chk("reload_E2_r1", results[1], 5);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
